muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit that sits directly upstream of the register file write port. The decode stage issues an M-extension operation with its two source operands and destination register. The unit computes the result over multiple cycles and presents it with a one-cycle write strobe (`regwrite_o`, `rd_o`, `result_o`) that drives the register file's `RegWrite_i`, `RDaddr_i` and `RDdata_i` through the writeback mux. While the unit is busy, the pipeline stalls on `busy_o`.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_step.sv | 35 +++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, the FSM state type and the default datapath width.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared 2*XLEN accumulator: shift-add for multiply
// ({hi, multiplier}) or restoring shift-subtract for divide ({rem, quotient}).
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     opnd,
    output logic [2*XLEN-1:0]   acc_next
);

    logic [XLEN:0] sum_s;
    logic [XLEN:0] diff_s;

    // Single multiply or divide iteration on the accumulator
    always_comb begin
        sum_s  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
        // Shifted partial remainder carries one extra bit before the trial subtract
        diff_s = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
        if (is_div) begin
            if (diff_s[XLEN]) begin
                acc_next = {acc[2*XLEN-2:0], 1'b0};
            end else begin
                acc_next = {diff_s[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end
        end else if (acc[0]) begin
            acc_next = {sum_s, acc[XLEN-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit feeding the register-file write port.
// Runs on operand magnitudes and applies sign correction on entry to DONE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             start_i,
    input  logic [2:0]       funct3_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [4:0]       rd_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [XLEN-1:0]  result_o,
    output logic [4:0]       rd_o,
    output logic             regwrite_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_r;
    logic [CW-1:0]     cnt_r;
    logic [2:0]        funct3_r;
    logic              neg_r;
    logic [2*XLEN-1:0] acc_r;
    logic [XLEN-1:0]   opnd_r;
    logic              busy_r;
    logic              done_r;
    logic              regwrite_r;
    logic [XLEN-1:0]   result_r;
    logic [4:0]        rd_r;

    logic              rs1_sgn_s, rs2_sgn_s, s1_s, s2_s;
    logic              div0_s, ovf_s, special_s, neg_in_s;
    logic [XLEN-1:0]   mag1_s, mag2_s, spec_res_s;
    logic [2*XLEN-1:0] acc_next_s, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, result_s;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div   (funct3_r[2]),
        .acc      (acc_r),
        .opnd     (opnd_r),
        .acc_next (acc_next_s)
    );

    // Operand signedness, magnitudes and special-case detection at accept
    always_comb begin
        rs1_sgn_s = 1'b0;
        rs2_sgn_s = 1'b0;
        case (funct3_i)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
                rs1_sgn_s = 1'b1;
                rs2_sgn_s = 1'b1;
            end
            F3_MULHSU: rs1_sgn_s = 1'b1;
            default: begin
                rs1_sgn_s = 1'b0;
                rs2_sgn_s = 1'b0;
            end
        endcase
        s1_s      = rs1_sgn_s & rs1_i[XLEN-1];
        s2_s      = rs2_sgn_s & rs2_i[XLEN-1];
        mag1_s    = s1_s ? -rs1_i : rs1_i;
        mag2_s    = s2_s ? -rs2_i : rs2_i;
        div0_s    = (rs2_i == ZERO);
        ovf_s     = funct3_i[2] && rs2_sgn_s && (rs1_i == XMIN) && (rs2_i == ONES);
        special_s = funct3_i[2] && (div0_s || ovf_s);
        // Remainder follows the dividend; product and quotient use the XOR
        neg_in_s  = (funct3_i[2] && funct3_i[1]) ? s1_s : (s1_s ^ s2_s);
        if (div0_s) begin
            spec_res_s = funct3_i[1] ? rs1_i : ONES;
        end else begin
            spec_res_s = funct3_i[1] ? ZERO : XMIN;
        end
    end

    // Sign correction and result selection for the final iteration
    always_comb begin
        prod_s = neg_r ? -acc_next_s : acc_next_s;
        quo_s  = neg_r ? -acc_next_s[XLEN-1:0] : acc_next_s[XLEN-1:0];
        rem_s  = neg_r ? -acc_next_s[2*XLEN-1:XLEN] : acc_next_s[2*XLEN-1:XLEN];
        case (funct3_r)
            F3_MUL:                       result_s = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result_s = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              result_s = quo_s;
            F3_REM, F3_REMU:              result_s = rem_s;
            default:                      result_s = ZERO;
        endcase
    end

    // Control FSM, iteration counter, operand latches and registered outputs
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            funct3_r   <= 3'b000;
            neg_r      <= 1'b0;
            acc_r      <= {(2*XLEN){1'b0}};
            opnd_r     <= ZERO;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            regwrite_r <= 1'b0;
            result_r   <= ZERO;
            rd_r       <= 5'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r     <= 1'b0;
                    regwrite_r <= 1'b0;
                    if (start_i) begin
                        funct3_r <= funct3_i;
                        rd_r     <= rd_i;
                        neg_r    <= neg_in_s;
                        cnt_r    <= CW'(XLEN - 1);
                        busy_r   <= 1'b1;
                        if (special_s) begin
                            state_r    <= DONE;
                            result_r   <= spec_res_s;
                            done_r     <= 1'b1;
                            regwrite_r <= (rd_i != 5'd0);
                        end else begin
                            state_r <= BUSY;
                            acc_r   <= {ZERO, (funct3_i[2] ? mag1_s : mag2_s)};
                            opnd_r  <= funct3_i[2] ? mag2_s : mag1_s;
                        end
                    end
                end
                BUSY: begin
                    acc_r <= acc_next_s;
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r    <= DONE;
                        result_r   <= result_s;
                        done_r     <= 1'b1;
                        regwrite_r <= (rd_r != 5'd0);
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    regwrite_r <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    regwrite_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_r;
    assign done_o     = done_r;
    assign regwrite_o = regwrite_r;
    assign result_o   = result_r;
    assign rd_o       = rd_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus randomized
// operations checked against a 64-bit arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i, rs2_i;
    logic [4:0]  rd_i;
    logic        busy_o, done_o, regwrite_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    muldiv_unit #(.XLEN(32)) dut (
        .clk_i      (clk_i),
        .reset      (reset),
        .start_i    (start_i),
        .funct3_i   (funct3_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .rd_i       (rd_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .rd_o       (rd_o),
        .regwrite_o (regwrite_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RV32M semantics computed with wide integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            3'b000: begin p = sa * sb;           return p[31:0];  end
            3'b001: begin p = sa * sb;           return p[63:32]; end
            3'b010: begin p = sa * longint'(ub); return p[63:32]; end
            3'b011: begin p = ua * ub;           return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                q = sa / sb; return q[31:0];
            end
            3'b101: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                p = ua / ub; return p[31:0];
            end
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                q = sa % sb; return q[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && (b == 32'd0 ||
               ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one operation, wait (bounded) for done_o, check latency/result/hold
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int c;
        int lat;
        lat = is_special(f3, a, b) ? 1 : 33;
        @(negedge clk_i);
        start_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b; rd_i = rd;
        @(posedge clk_i); #1;
        start_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom; rd_i = 5'($urandom);
        c = 1;
        check({tag, "/busy"}, 32'(busy_o), 32'd1);
        while (done_o !== 1'b1 && c < 40) begin
            @(posedge clk_i); #1;
            c++;
        end
        check({tag, "/latency"}, 32'(c), 32'(lat));
        check({tag, "/result"}, result_o, exp);
        check({tag, "/rd"}, 32'(rd_o), 32'(rd));
        check({tag, "/regwrite"}, 32'(regwrite_o), 32'(rd != 5'd0));
        @(posedge clk_i); #1;
        check({tag, "/done_low"}, 32'(done_o), 32'd0);
        check({tag, "/idle"}, 32'(busy_o), 32'd0);
        check({tag, "/hold"}, result_o, exp);
    endtask

    initial begin
        int dones;
        int c;
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [4:0]  rd;

        reset = 1'b1; start_i = 1'b0; funct3_i = 3'b000;
        rs1_i = 32'd0; rs2_i = 32'd0; rd_i = 5'd0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst/busy", 32'(busy_o), 32'd0);
        check("rst/done", 32'(done_o), 32'd0);
        check("rst/regwrite", 32'(regwrite_o), 32'd0);
        check("rst/result", result_o, 32'd0);
        check("rst/rd", 32'(rd_o), 32'd0);
        @(negedge clk_i); reset = 1'b0;

        run_op("mul",    F3_MUL,   32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB);
        run_op("mulh",   F3_MULH,  32'h80000000,   32'h80000000, 5'd6,  32'h40000000);
        run_op("mulhu",  F3_MULHU, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE);
        run_op("div",    F3_DIV,   32'hFFFFFFF9,   32'd2,        5'd8,  32'hFFFFFFFD);
        run_op("rem",    F3_REM,   32'hFFFFFFF9,   32'd2,        5'd9,  32'hFFFFFFFF);
        run_op("divu",   F3_DIVU,  32'd100,        32'd7,        5'd10, 32'd14);
        run_op("remu",   F3_REMU,  32'd100,        32'd7,        5'd11, 32'd2);
        run_op("div0",   F3_DIV,   32'd5,          32'd0,        5'd12, 32'hFFFFFFFF);
        run_op("rem0",   F3_REM,   32'd5,          32'd0,        5'd13, 32'd5);
        run_op("divovf", F3_DIV,   32'h80000000,   32'hFFFFFFFF, 5'd14, 32'h80000000);
        run_op("removf", F3_REM,   32'h80000000,   32'hFFFFFFFF, 5'd15, 32'd0);
        run_op("rd0",    F3_DIVU,  32'd100,        32'd7,        5'd0,  32'd14);

        // start_i held high: one done, then a fresh accept right after DONE
        @(negedge clk_i);
        start_i = 1'b1; funct3_i = F3_MUL; rs1_i = 32'd6; rs2_i = 32'd7; rd_i = 5'd3;
        dones = 0;
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk_i); #1;
            if (done_o === 1'b1) dones++;
            if (k == 33) check("held/done33", 32'(done_o), 32'd1);
        end
        check("held/one_done", 32'(dones), 32'd1);
        check("held/idle_gap", 32'(busy_o), 32'd0);
        @(posedge clk_i); #1;
        check("held/reaccept", 32'(busy_o), 32'd1);
        @(negedge clk_i); start_i = 1'b0;
        c = 1;
        while (done_o !== 1'b1 && c < 40) begin
            @(posedge clk_i); #1;
            c++;
        end
        check("held/latency2", 32'(c), 32'd33);
        check("held/result2", result_o, 32'd42);
        @(posedge clk_i); #1;

        // Reset during cycle 10 of a divide drops the operation
        @(negedge clk_i);
        start_i = 1'b1; funct3_i = F3_DIV; rs1_i = 32'd1000; rs2_i = 32'd3; rd_i = 5'd17;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int k = 2; k <= 10; k++) begin
            @(posedge clk_i); #1;
        end
        @(negedge clk_i); reset = 1'b1;
        @(posedge clk_i); #1;
        check("mrst/busy", 32'(busy_o), 32'd0);
        check("mrst/done", 32'(done_o), 32'd0);
        check("mrst/regwrite", 32'(regwrite_o), 32'd0);
        check("mrst/result", result_o, 32'd0);
        check("mrst/rd", 32'(rd_o), 32'd0);
        @(negedge clk_i); reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk_i); #1;
            if (done_o === 1'b1) dones++;
        end
        check("mrst/no_done", 32'(dones), 32'd0);
        run_op("mul3x4", F3_MUL, 32'd3, 32'd4, 5'd1, 32'd12);

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = rand_opnd();
            b  = rand_opnd();
            rd = 5'($urandom);
            run_op("rand", f3, a, b, rd, ref_model(f3, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
